// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: zero-latency pipeline writeback (A) with
// a small FIFO of multi-cycle unit writes (B) and a bounded starvation guard.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        RegWrite,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData,
    input  logic [4:0]  rs1Addr,
    input  logic [4:0]  rs2Addr,
    output logic        rs1_pending,
    output logic        rs2_pending,
    output logic        a_stall,
    output logic        err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [SW-1:0] STV_MAX = SW'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, FORCE} state_e;

    state_e        state_q;
    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q;
    logic          a_stall_q, err_q;

    logic          a_req, a_win, deq, enq, starve_hit;
    logic          rs1_hit, rs2_hit;
    logic [PW-1:0] slot;

    // Requests to x0 are dropped at the boundary; rst suppresses any write.
    assign a_req      = a_valid && (a_addr != 5'd0) && !rst;
    assign a_win      = a_req && (state_q != FORCE);
    assign deq        = !rst && !a_win && (state_q != IDLE) && (count_q != '0);
    assign b_ready    = (count_q != FULL);
    assign enq        = b_valid && b_ready && (b_addr != 5'd0);
    assign starve_hit = a_win && (state_q == DRAIN) && (starve_q == STV_MAX);
    assign count_d    = count_q + CW'(enq) - CW'(deq);

    assign a_stall = a_stall_q;
    assign err     = err_q;

    always_comb begin
        RegWrite  = 1'b0;
        WriteAddr = 5'd0;
        WriteData = 32'd0;
        if (a_win) begin
            RegWrite  = 1'b1;
            WriteAddr = a_addr;
            WriteData = a_data;
        end else if (deq) begin
            RegWrite  = 1'b1;
            WriteAddr = addr_q[rd_ptr_q];
            WriteData = data_q[rd_ptr_q];
        end
    end

    // Hazard lookup covers only occupied slots, never the b_addr input.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        slot    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = PW'(i) - rd_ptr_q;
            if (CW'(slot) < count_q) begin
                if (addr_q[i] == rs1Addr) rs1_hit = 1'b1;
                if (addr_q[i] == rs2Addr) rs2_hit = 1'b1;
            end
        end
        rs1_pending = rs1_hit && (rs1Addr != 5'd0);
        rs2_pending = rs2_hit && (rs2Addr != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr_q] <= b_addr;
            data_q[wr_ptr_q] <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            a_stall_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q   <= count_d;
            a_stall_q <= starve_hit;
            if (state_q == FORCE && a_req) err_q <= 1'b1;
            if (starve_hit) begin
                state_q <= FORCE;
            end else if (count_d != '0) begin
                state_q <= DRAIN;
            end else begin
                state_q <= IDLE;
            end
            if (deq || count_d == '0) begin
                starve_q <= '0;
            end else if (a_win && state_q == DRAIN) begin
                starve_q <= starve_q + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, then random traffic
// checked against a queue-based model of the arbitration rules.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr, rs1Addr, rs2Addr;
    logic [31:0] a_data, b_data;
    logic        b_ready, RegWrite, rs1_pending, rs2_pending, a_stall, err;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
        .b_ready(b_ready),
        .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
        .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .a_stall(a_stall), .err(err)
    );

    typedef struct {
        int r, av, aa, ad, bv, ba, bd, rs;
        int we, wa, wd, br, p, st, er;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int r, input int av, input int aa, input int ad,
                         input int bv, input int ba, input int bd,
                         input int r1, input int r2);
        rst     = 1'(r);
        a_valid = 1'(av);
        a_addr  = 5'(aa);
        a_data  = 32'(ad);
        b_valid = 1'(bv);
        b_addr  = 5'(ba);
        b_data  = 32'(bd);
        rs1Addr = 5'(r1);
        rs2Addr = 5'(r2);
    endtask

    logic [36:0] q[$];
    int          starve_m;
    bit          force_m, err_m;

    function automatic bit in_q(input logic [4:0] a);
        foreach (q[k]) if (q[k][36:32] == a) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        // r av aa ad bv ba bd rs | we wa wd br p st er
        tbl.push_back('{0,0,0,0,    0,0,0,0,     0,0,0,1,0,0,0});
        tbl.push_back('{0,1,5,'h11, 0,0,0,0,     1,5,'h11,1,0,0,0});
        tbl.push_back('{0,1,0,'h22, 0,0,0,0,     0,0,0,1,0,0,0});
        tbl.push_back('{0,1,3,'h33, 1,7,'h70,0,  1,3,'h33,1,0,0,0});
        tbl.push_back('{0,1,4,'h44, 1,8,'h80,7,  1,4,'h44,1,1,0,0});
        tbl.push_back('{0,1,5,'h55, 1,9,'h90,8,  1,5,'h55,0,1,0,0});
        tbl.push_back('{0,1,6,'h66, 1,9,'h90,9,  1,6,'h66,0,0,0,0});
        tbl.push_back('{0,1,10,'hAA,1,9,'h90,8,  1,10,'hAA,0,1,0,0});
        tbl.push_back('{0,0,0,0,    1,9,'h90,9,  1,7,'h70,0,0,1,0});
        tbl.push_back('{0,0,0,0,    0,0,0,8,     1,8,'h80,1,1,0,0});
        tbl.push_back('{0,0,0,0,    0,0,0,8,     0,0,0,1,0,0,0});
        tbl.push_back('{0,1,1,'h01, 1,7,'h71,0,  1,1,'h01,1,0,0,0});
        tbl.push_back('{0,1,2,'h02, 0,0,0,0,     1,2,'h02,1,0,0,0});
        tbl.push_back('{0,1,3,'h03, 0,0,0,0,     1,3,'h03,1,0,0,0});
        tbl.push_back('{0,1,4,'h04, 0,0,0,0,     1,4,'h04,1,0,0,0});
        tbl.push_back('{0,1,5,'h05, 0,0,0,7,     1,5,'h05,1,1,0,0});
        tbl.push_back('{0,1,6,'h66, 0,0,0,7,     1,7,'h71,1,1,1,0});
        tbl.push_back('{0,0,0,0,    0,0,0,0,     0,0,0,1,0,0,1});
        tbl.push_back('{0,1,9,'h99, 0,0,0,0,     1,9,'h99,1,0,0,1});
        tbl.push_back('{0,1,1,'h01, 1,12,'hC0,0, 1,1,'h01,1,0,0,1});
        tbl.push_back('{0,1,2,'h02, 1,13,'hD0,0, 1,2,'h02,1,0,0,1});
        tbl.push_back('{0,0,0,0,    0,0,0,12,    1,12,'hC0,0,1,0,1});
        tbl.push_back('{1,0,0,0,    0,0,0,0,     0,0,0,1,0,0,1});
        tbl.push_back('{0,0,0,0,    0,0,0,13,    0,0,0,1,0,0,0});
        tbl.push_back('{0,0,0,0,    1,0,5,0,     0,0,0,1,0,0,0});
        tbl.push_back('{0,0,0,0,    0,0,0,0,     0,0,0,1,0,0,0});

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            vec_t v;
            string t;
            v = tbl[i];
            @(negedge clk);
            drive(v.r, v.av, v.aa, v.ad, v.bv, v.ba, v.bd, v.rs, v.rs);
            #2;
            t = $sformatf("row%0d", i);
            check({t, " RegWrite"},    32'(RegWrite),    32'(v.we));
            check({t, " WriteAddr"},   32'(WriteAddr),   32'(v.wa));
            check({t, " WriteData"},   WriteData,        32'(v.wd));
            check({t, " b_ready"},     32'(b_ready),     32'(v.br));
            check({t, " rs1_pending"}, 32'(rs1_pending), 32'(v.p));
            check({t, " rs2_pending"}, 32'(rs2_pending), 32'(v.p));
            check({t, " a_stall"},     32'(a_stall),     32'(v.st));
            check({t, " err"},         32'(err),         32'(v.er));
        end

        q.delete();
        starve_m = 0;
        force_m  = 1'b0;
        err_m    = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            bit          r, av, bv, areq, pop, br, we, nf;
            logic [4:0]  aa, ba, r1, r2, wa;
            logic [31:0] ad, bd, wd;
            string       t;
            r  = (c == 0) || ($urandom_range(0, 99) == 0);
            av = ($urandom_range(0, 9) < 7);
            aa = 5'($urandom_range(0, 7));
            ad = $urandom;
            bv = 1'($urandom_range(0, 1));
            ba = 5'($urandom_range(0, 7));
            bd = $urandom;
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            @(negedge clk);
            drive(r, av, aa, ad, bv, ba, bd, r1, r2);
            #2;
            areq = av && aa != 0;
            br   = q.size() < DEPTH;
            pop  = 1'b0;
            we   = 1'b0;
            wa   = 0;
            wd   = 0;
            if (!r) begin
                if (force_m || (!areq && q.size() > 0)) begin
                    we  = 1'b1;
                    wa  = q[0][36:32];
                    wd  = q[0][31:0];
                    pop = 1'b1;
                end else if (areq) begin
                    we = 1'b1;
                    wa = aa;
                    wd = ad;
                end
            end
            t = $sformatf("rand%0d", c);
            check({t, " RegWrite"},    32'(RegWrite),    32'(we));
            check({t, " WriteAddr"},   32'(WriteAddr),   32'(wa));
            check({t, " WriteData"},   WriteData,        wd);
            check({t, " b_ready"},     32'(b_ready),     32'(br));
            check({t, " rs1_pending"}, 32'(rs1_pending), 32'(r1 != 0 && in_q(r1)));
            check({t, " rs2_pending"}, 32'(rs2_pending), 32'(r2 != 0 && in_q(r2)));
            check({t, " a_stall"},     32'(a_stall),     32'(force_m));
            check({t, " err"},         32'(err),         32'(err_m));
            if (r) begin
                q.delete();
                starve_m = 0;
                force_m  = 1'b0;
                err_m    = 1'b0;
            end else begin
                nf = 1'b0;
                if (force_m && areq) err_m = 1'b1;
                if (!force_m && areq && q.size() > 0) begin
                    starve_m++;
                    if (starve_m == LIMIT) nf = 1'b1;
                end
                if (pop) begin
                    void'(q.pop_front());
                    starve_m = 0;
                end
                if (bv && br && ba != 0) q.push_back({ba, bd});
                if (q.size() == 0) starve_m = 0;
                force_m = nf;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
